// File: rtl/button_event_ctrl_if.sv
// Avalon-MM register bus between the Nios interconnect and button_event_ctrl.
// Ports (as seen by the slave):
//   address    - register select (0 DATA, 1 MASK, 2 EDGE, 3 DIV)
//   chipselect - slave select
//   write      - write strobe, qualified by chipselect
//   writedata  - write data
//   readdata   - registered read data, one cycle after address
interface button_event_ctrl_if;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, chipselect, write, writedata, input readdata);
    modport slave  (input address, chipselect, write, writedata, output readdata);
endinterface

// File: rtl/button_event_ctrl.sv
// Push-button conditioner: 2-FF synchroniser, tick-sampled debounce, sticky
// press capture (write-1-to-clear) and a maskable level interrupt.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   bus     - Avalon-MM slave (DATA/MASK/EDGE/DIV registers)
//   in_port - raw asynchronous button pins
//   irq     - registered interrupt, |(EDGE & MASK)
module button_event_ctrl #(
    parameter int unsigned WIDTH          = 8,
    parameter logic [15:0] DIV_RESET      = 16'd49999,
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    button_event_ctrl_if.slave bus,
    input  logic [WIDTH-1:0]   in_port,
    output logic               irq
);
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned RUN_W  = 3;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_DIV  = 2'd3;

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_SAMPLES - 1);
    // Synchroniser reset value is the released pin level, so no false press.
    localparam logic [WIDTH-1:0] PIN_IDLE = {WIDTH{ACTIVE_LOW}};

    logic [WIDTH-1:0]             sync1_q, sync1_d;
    logic [WIDTH-1:0]             sync2_q, sync2_d;
    logic [WIDTH-1:0]             lvl_q, lvl_d;
    logic [WIDTH-1:0][RUN_W-1:0]  run_q, run_d;
    logic [WIDTH-1:0]             mask_q, mask_d;
    logic [WIDTH-1:0]             edge_q, edge_d;
    logic [DIV_W-1:0]             div_q, div_d;
    logic [DIV_W-1:0]             cnt_q, cnt_d;
    logic [DATA_W-1:0]            readdata_q, readdata_d;
    logic                         irq_q, irq_d;

    logic                         wr_en_c;
    logic                         div_wr_c;
    logic                         tick_c;
    logic [WIDTH-1:0]             sample_c;
    logic [WIDTH-1:0]             edge_clr_c;
    logic                         unused_wdata_c;

    // Upper write-data bits have no register behind them.
    assign unused_wdata_c = ^bus.writedata[DATA_W-1:DIV_W];

    // Next-state logic for all registers.
    always_comb begin
        sync1_d    = in_port;
        sync2_d    = sync1_q;
        lvl_d      = lvl_q;
        run_d      = run_q;
        mask_d     = mask_q;
        edge_d     = edge_q;
        div_d      = div_q;
        cnt_d      = cnt_q + DIV_W'(1);
        readdata_d = '0;
        irq_d      = |(edge_q & mask_q);

        wr_en_c    = bus.chipselect & bus.write;
        div_wr_c   = wr_en_c && (bus.address == ADDR_DIV);
        // A DIV write restarts the prescaler and swallows that cycle's tick.
        tick_c     = !div_wr_c && (cnt_q == div_q);
        sample_c   = ACTIVE_LOW ? ~sync2_q : sync2_q;
        edge_clr_c = '0;

        if (div_wr_c || tick_c) begin
            cnt_d = '0;
        end
        if (div_wr_c) begin
            div_d = bus.writedata[DIV_W-1:0];
        end
        if (wr_en_c && (bus.address == ADDR_MASK)) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr_en_c && (bus.address == ADDR_EDGE)) begin
            edge_clr_c = bus.writedata[WIDTH-1:0];
        end

        // Debounce: flip on the STABLE_SAMPLES-th consecutive differing tick.
        if (tick_c) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sample_c[i] == lvl_q[i]) begin
                    run_d[i] = '0;
                end else if (run_q[i] == RUN_LAST) begin
                    lvl_d[i] = ~lvl_q[i];
                    run_d[i] = '0;
                end else begin
                    run_d[i] = run_q[i] + RUN_W'(1);
                end
            end
        end

        // Press capture: a new press overrides a simultaneous clear.
        edge_d = (edge_q & ~edge_clr_c) | (lvl_d & ~lvl_q);

        unique case (bus.address)
            ADDR_DATA: readdata_d = DATA_W'(lvl_q);
            ADDR_MASK: readdata_d = DATA_W'(mask_q);
            ADDR_EDGE: readdata_d = DATA_W'(edge_q);
            ADDR_DIV:  readdata_d = DATA_W'(div_q);
            default:   readdata_d = '0;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= PIN_IDLE;
            sync2_q    <= PIN_IDLE;
            lvl_q      <= '0;
            run_q      <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            div_q      <= DIV_RESET;
            cnt_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_q      <= lvl_d;
            run_q      <= run_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;
endmodule
